// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_pkg
// Description : Shared scan-state encoding, pin polarity helper and default
//               matrix geometry for the row-scanned LED matrix driver.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package led_matrix_pkg;

  localparam int c_DEFAULT_ROWS = 8;
  localparam int c_DEFAULT_COLS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Map a logical "lit" bit onto the physical pin level.
  function automatic logic pin_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_gate.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_gate
// Description : Global brightness comparator. The top BRIGHT_W bits of the
//               row dwell counter are compared against the latched brightness;
//               an all-ones brightness forces full duty.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_gate #(
  parameter int BRIGHT_W = 4
) (
  input  logic [BRIGHT_W-1:0] dwell_field,
  input  logic [BRIGHT_W-1:0] bright,
  output logic                pwm_on
);

  assign pwm_on = (dwell_field < bright) || (&bright);

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan_drv.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_scan_drv
// Description : Parametrised row-scanned LED matrix driver. Double-buffers a
//               ROWS x COLS bitmap behind a valid/ready handshake, lights one
//               row at a time with an anti-ghosting blank before each row and
//               applies global PWM brightness. All outputs are registered.
// Revision    : 1.0 - successor to the fixed 8x8 persistence-of-vision driver
// ============================================================================
module led_matrix_scan_drv
  import led_matrix_pkg::*;
#(
  parameter int ROWS           = c_DEFAULT_ROWS,
  parameter int COLS           = c_DEFAULT_COLS,
  parameter int DWELL_W        = 13,
  parameter int BLANK_CYCLES   = 16,
  parameter int BRIGHT_W       = 4,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [BRIGHT_W-1:0]  brightness,
  output logic [ROWS-1:0]      led_row,
  output logic [COLS-1:0]      led_col,
  output logic                 frame_start
);

  localparam int                   c_ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int                   c_BLANK_W    = $clog2(BLANK_CYCLES + 1);
  localparam logic [c_ROW_W-1:0]   c_LAST_ROW   = c_ROW_W'(ROWS - 1);
  localparam logic [c_BLANK_W-1:0] c_BLANK_LAST = c_BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [ROWS-1:0]      c_ROW_ONE    = ROWS'(1);
  localparam logic                 c_ROW_LOW    = (ROW_ACTIVE_LOW != 0);
  localparam logic                 c_COL_LOW    = (COL_ACTIVE_LOW != 0);

  // Scan state and counters
  scan_state_t            r_state;
  logic [c_ROW_W-1:0]     r_row_idx;
  logic [c_BLANK_W-1:0]   r_blank_cnt;
  logic [DWELL_W-1:0]     r_dwell_cnt;

  // Frame buffers and latched brightness
  logic [ROWS*COLS-1:0]   r_display;
  logic [ROWS*COLS-1:0]   r_pending;
  logic                   r_pending_full;
  logic [BRIGHT_W-1:0]    r_bright_q;

  // Registered pins
  logic [ROWS-1:0]        r_led_row;
  logic [COLS-1:0]        r_led_col;
  logic                   r_frame_start;

  // Next-state values
  scan_state_t            w_state_nxt;
  logic [c_ROW_W-1:0]     w_row_nxt;
  logic [c_BLANK_W-1:0]   w_blank_nxt;
  logic [DWELL_W-1:0]     w_dwell_nxt;
  logic                   w_boundary;
  logic                   w_accept;
  logic [ROWS*COLS-1:0]   w_display_nxt;
  logic [BRIGHT_W-1:0]    w_bright_nxt;
  logic                   w_pwm_on;
  logic [ROWS-1:0]        w_row_on;
  logic [COLS-1:0]        w_col_on;
  logic [ROWS-1:0]        w_row_pin;
  logic [COLS-1:0]        w_col_pin;

  assign w_accept   = data_valid && !r_pending_full;
  assign data_ready = !r_pending_full;

  // Scan sequencing: IDLE -> BLANK -> SHOW per row; enable low forces IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_idx;
    w_blank_nxt = r_blank_cnt;
    w_dwell_nxt = r_dwell_cnt;
    w_boundary  = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = '0;
      w_blank_nxt = '0;
      w_dwell_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_row_nxt   = '0;
          w_blank_nxt = '0;
          w_dwell_nxt = '0;
          w_boundary  = 1'b1;
        end
        ST_BLANK: begin
          if (r_blank_cnt == c_BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_blank_nxt = '0;
            w_dwell_nxt = '0;
          end else begin
            w_blank_nxt = r_blank_cnt + c_BLANK_W'(1);
          end
        end
        ST_SHOW: begin
          if (&r_dwell_cnt) begin
            w_state_nxt = ST_BLANK;
            w_blank_nxt = '0;
            w_dwell_nxt = '0;
            if (r_row_idx == c_LAST_ROW) begin
              w_row_nxt  = '0;
              w_boundary = 1'b1;
            end else begin
              w_row_nxt = r_row_idx + c_ROW_W'(1);
            end
          end else begin
            w_dwell_nxt = r_dwell_cnt + DWELL_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_row_nxt   = '0;
          w_blank_nxt = '0;
          w_dwell_nxt = '0;
        end
      endcase
    end
  end

  // Buffer swap and brightness latch happen only at a frame boundary.
  always_comb begin
    w_display_nxt = r_display;
    w_bright_nxt  = r_bright_q;
    if (w_boundary) begin
      w_bright_nxt = brightness;
      if (r_pending_full) begin
        w_display_nxt = r_pending;
      end
    end
  end

  led_pwm_gate #(
    .BRIGHT_W (BRIGHT_W)
  ) u_pwm_gate (
    .dwell_field (w_dwell_nxt[DWELL_W-1 -: BRIGHT_W]),
    .bright      (w_bright_nxt),
    .pwm_on      (w_pwm_on)
  );

  // Logical pin values for the upcoming cycle, derived from next-state so the
  // registered pins line up with the registered scan state.
  always_comb begin
    w_row_on = '0;
    w_col_on = '0;
    if (w_state_nxt == ST_SHOW) begin
      w_row_on = c_ROW_ONE << w_row_nxt;
      if (w_pwm_on) begin
        w_col_on = w_display_nxt[int'(w_row_nxt)*COLS +: COLS];
      end
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row_pin
    assign w_row_pin[i] = pin_level(w_row_on[i], c_ROW_LOW);
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col_pin
    assign w_col_pin[j] = pin_level(w_col_on[j], c_COL_LOW);
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_row_idx   <= '0;
      r_blank_cnt <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_idx   <= w_row_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_dwell_cnt <= w_dwell_nxt;
    end
  end

  // Input handshake into the pending buffer and display/brightness update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_display      <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_bright_q     <= '0;
    end else begin
      r_display  <= w_display_nxt;
      r_bright_q <= w_bright_nxt;
      if (w_accept) begin
        r_pending      <= data;
        r_pending_full <= 1'b1;
      end else if (w_boundary) begin
        r_pending_full <= 1'b0;
      end
    end
  end

  // Registered board pins and frame marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led_row     <= {ROWS{c_ROW_LOW}};
      r_led_col     <= {COLS{c_COL_LOW}};
      r_frame_start <= 1'b0;
    end else begin
      r_led_row     <= w_row_pin;
      r_led_col     <= w_col_pin;
      r_frame_start <= w_boundary;
    end
  end

  assign led_row     = r_led_row;
  assign led_col     = r_led_col;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_matrix_scan_drv
// Description : Self-checking bench for led_matrix_scan_drv (4x4, slot 10,
//               frame 40). Two instances share stimulus: one with active-high
//               pins, one with active-low pins. Expected values come from a
//               time-based model of the scan schedule.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_led_matrix_scan_drv;

  localparam int R     = 4;
  localparam int C     = 4;
  localparam int DW    = 3;
  localparam int BC    = 2;
  localparam int BW    = 2;
  localparam int SLOT  = BC + (1 << DW);
  localparam int FRAME = R * SLOT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [R*C-1:0] data;
  logic          data_valid;
  logic [BW-1:0] brightness;
  logic          data_ready, data_ready_n;
  logic [R-1:0]  led_row, led_row_n;
  logic [C-1:0]  led_col, led_col_n;
  logic          frame_start, frame_start_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_matrix_scan_drv #(
    .ROWS(R), .COLS(C), .DWELL_W(DW), .BLANK_CYCLES(BC), .BRIGHT_W(BW),
    .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data),
    .data_valid(data_valid), .data_ready(data_ready), .brightness(brightness),
    .led_row(led_row), .led_col(led_col), .frame_start(frame_start)
  );

  led_matrix_scan_drv #(
    .ROWS(R), .COLS(C), .DWELL_W(DW), .BLANK_CYCLES(BC), .BRIGHT_W(BW),
    .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data),
    .data_valid(data_valid), .data_ready(data_ready_n), .brightness(brightness),
    .led_row(led_row_n), .led_col(led_col_n), .frame_start(frame_start_n)
  );

  // ---------------- reference model ----------------
  // m_t counts clocks since the most recent frame boundary while scanning.
  bit            m_run = 1'b0;
  int            m_t = 0;
  logic [R*C-1:0] m_disp = '0;
  logic [R*C-1:0] m_pend = '0;
  bit            m_pend_full = 1'b0;
  logic [BW-1:0] m_bright = '0;
  bit            m_fs = 1'b0;
  bit            m_acc = 1'b0;

  always @(posedge clk) begin : model
    bit acc, bnd;
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pend_full = 0;
      m_bright = '0; m_fs = 0; m_acc = 0;
    end else begin
      acc = data_valid && !m_pend_full;
      bnd = 0;
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0; bnd = 1;
      end else begin
        m_t = (m_t + 1) % FRAME;
        bnd = (m_t == 0);
      end
      if (bnd) begin
        if (m_pend_full) begin m_disp = m_pend; m_pend_full = 0; end
        m_bright = brightness;
      end
      if (acc) begin m_pend = data; m_pend_full = 1; end
      m_fs  = bnd;
      m_acc = acc;
    end
  end

  function automatic logic [R-1:0] exp_row();
    int slot;
    slot = m_t % SLOT;
    if (!m_run || slot < BC) return '0;
    return R'(1) << (m_t / SLOT);
  endfunction

  function automatic logic [C-1:0] exp_col();
    int slot, r, dwell;
    slot = m_t % SLOT;
    if (!m_run || slot < BC) return '0;
    r     = m_t / SLOT;
    dwell = slot - BC;
    if (((dwell >> (DW - BW)) < int'(m_bright)) || (m_bright == {BW{1'b1}}))
      return m_disp[r*C +: C];
    return '0;
  endfunction

  function automatic int row_index(input logic [R-1:0] v);
    for (int i = 0; i < R; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Bounded waits: report whether the event was seen; callers compare.
  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_row(input logic [R-1:0] pat, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (led_row === pat) begin ok = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; enable = 0; data_valid = 0; data = '0; brightness = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (led_row !== 4'b0000) begin n_errors++; $display("FAIL reset_row: got %b want 0000", led_row); end
    n_checks++; if (led_col !== 4'b0000) begin n_errors++; $display("FAIL reset_col: got %b want 0000", led_col); end
    n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    n_checks++; if (data_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", data_ready); end
    n_checks++; if (led_row_n !== 4'b1111) begin n_errors++; $display("FAIL reset_row_n: got %b want 1111", led_row_n); end
    n_checks++; if (led_col_n !== 4'b1111) begin n_errors++; $display("FAIL reset_col_n: got %b want 1111", led_col_n); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_checks++; if (led_row !== 4'b0000 || frame_start !== 1'b0) begin n_errors++; $display("FAIL idle_hold: row %b fs %b want 0000 0", led_row, frame_start); end
  endtask

  task automatic test_scan_order();
    enable = 1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      n_checks++; if (led_row !== exp_row()) begin n_errors++; $display("FAIL scan_row k=%0d: got %b want %b", k, led_row, exp_row()); end
      n_checks++; if (frame_start !== m_fs) begin n_errors++; $display("FAIL scan_fs k=%0d: got %b want %b", k, frame_start, m_fs); end
      n_checks++; if (led_col !== exp_col()) begin n_errors++; $display("FAIL scan_col k=%0d: got %b want %b", k, led_col, exp_col()); end
      if (k == 0) begin
        n_checks++; if (frame_start !== 1'b1 || led_row !== 4'b0000) begin n_errors++; $display("FAIL scan_first: fs %b row %b want 1 0000", frame_start, led_row); end
      end
      if (k == 2 || k == 12 || k == 22 || k == 32 || k == 42) begin
        n_checks++;
        if (led_row !== (4'b0001 << ((k / SLOT) % R))) begin n_errors++; $display("FAIL scan_step k=%0d: got %b", k, led_row); end
      end
    end
  endtask

  task automatic test_bitmap();
    bit ok;
    logic [C-1:0] nib [R];
    int lit [R];
    nib[0] = 4'h3; nib[1] = 4'hC; nib[2] = 4'h5; nib[3] = 4'hA;
    for (int r = 0; r < R; r++) lit[r] = 0;
    wait_row(4'b0010, ok);
    data = 16'hA5C3; data_valid = 1; brightness = 2'd3;
    @(negedge clk);
    n_checks++; if (data_ready !== 1'b0) begin n_errors++; $display("FAIL bitmap_accept: ready %b want 0", data_ready); end
    data_valid = 0;
    wait_fs(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL bitmap_wait_fs: timeout"); end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++; if (led_col !== exp_col()) begin n_errors++; $display("FAIL bitmap_col k=%0d: got %h want %h", k, led_col, exp_col()); end
      if (row_index(led_row) >= 0) begin
        n_checks++;
        if (led_col !== nib[row_index(led_row)]) begin n_errors++; $display("FAIL bitmap_nib row=%0d: got %h want %h", row_index(led_row), led_col, nib[row_index(led_row)]); end
        lit[row_index(led_row)]++;
      end
    end
    for (int r = 0; r < R; r++) begin
      n_checks++; if (lit[r] != 8) begin n_errors++; $display("FAIL bitmap_lit row=%0d: got %0d want 8", r, lit[r]); end
    end
  endtask

  task automatic test_pwm();
    bit ok;
    int on_cnt, row_cnt;
    brightness = 2'd1;
    wait_fs(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL pwm_wait_fs: timeout"); end
    on_cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++; if (led_col !== exp_col()) begin n_errors++; $display("FAIL pwm1_col k=%0d: got %b want %b", k, led_col, exp_col()); end
      if (led_col !== 4'b0000) begin
        on_cnt++;
        n_checks++; if ((k % SLOT) - BC > 1 || (k % SLOT) < BC) begin n_errors++; $display("FAIL pwm1_phase k=%0d: lit outside SHOW clocks 0-1", k); end
      end
    end
    n_checks++; if (on_cnt != 2 * R) begin n_errors++; $display("FAIL pwm1_duty: got %0d want %0d", on_cnt, 2 * R); end
    brightness = 2'd0;
    wait_fs(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL pwm0_wait_fs: timeout"); end
    row_cnt = 0; on_cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (led_row !== 4'b0000) row_cnt++;
      if (led_col !== 4'b0000) on_cnt++;
      n_checks++; if (led_row !== exp_row()) begin n_errors++; $display("FAIL pwm0_row k=%0d: got %b want %b", k, led_row, exp_row()); end
    end
    n_checks++; if (on_cnt != 0) begin n_errors++; $display("FAIL pwm0_dark: got %0d lit clocks want 0", on_cnt); end
    n_checks++; if (row_cnt != 8 * R) begin n_errors++; $display("FAIL pwm0_strobe: got %0d want %0d", row_cnt, 8 * R); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [R*C-1:0] fx, fy, exp_frame;
    int guard;
    fx = 16'($urandom); fy = 16'($urandom);
    brightness = 2'd3;
    wait_row(4'b0010, ok);
    data = fx; data_valid = 1;
    @(negedge clk);
    n_checks++; if (data_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_x_accept: ready %b want 0", data_ready); end
    data = fy;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
      if (frame_start !== 1'b1) begin
        n_checks++; if (data_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_stall: ready %b want 0", data_ready); end
      end
    end
    n_checks++; if (frame_start !== 1'b1) begin n_errors++; $display("FAIL b2b_wait_fs: timeout"); end
    n_checks++; if (data_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_back: ready %b want 1", data_ready); end
    for (int f = 0; f < 2; f++) begin
      exp_frame = (f == 0) ? fx : fy;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (f == 0 && k == 1) begin
          n_checks++; if (data_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_y_accept: ready %b want 0", data_ready); end
          data_valid = 0;
        end
        n_checks++; if (led_col !== exp_col()) begin n_errors++; $display("FAIL b2b_col f=%0d k=%0d: got %h want %h", f, k, led_col, exp_col()); end
        if (row_index(led_row) >= 0) begin
          n_checks++;
          if (led_col !== exp_frame[row_index(led_row)*C +: C]) begin n_errors++; $display("FAIL b2b_frame f=%0d k=%0d: got %h want %h", f, k, led_col, exp_frame[row_index(led_row)*C +: C]); end
        end
      end
      @(negedge clk);
      n_checks++; if (frame_start !== 1'b1) begin n_errors++; $display("FAIL b2b_period f=%0d: fs %b want 1", f, frame_start); end
    end
  endtask

  task automatic test_polarity();
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      n_checks++; if (led_row_n !== ~exp_row()) begin n_errors++; $display("FAIL pol_row k=%0d: got %b want %b", k, led_row_n, ~exp_row()); end
      n_checks++; if (led_col_n !== ~exp_col()) begin n_errors++; $display("FAIL pol_col k=%0d: got %b want %b", k, led_col_n, ~exp_col()); end
      if (exp_row() == 4'b0001) begin
        n_checks++; if (led_row_n !== 4'b1110) begin n_errors++; $display("FAIL pol_row0: got %b want 1110", led_row_n); end
      end
    end
  endtask

  task automatic test_enable_reset();
    bit ok;
    int lit;
    brightness = 2'd3;
    wait_row(4'b0100, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL er_wait_row2: timeout"); end
    @(negedge clk);
    enable = 0;
    @(negedge clk);
    n_checks++; if (led_row !== 4'b0000 || led_col !== 4'b0000) begin n_errors++; $display("FAIL er_dark: row %b col %b want 0000 0000", led_row, led_col); end
    n_checks++; if (led_row_n !== 4'b1111 || led_col_n !== 4'b1111) begin n_errors++; $display("FAIL er_dark_n: row %b col %b want 1111 1111", led_row_n, led_col_n); end
    data = 16'hFFFF; data_valid = 1;
    @(negedge clk);
    data_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; enable = 1;
    n_checks++; if (data_ready !== 1'b1) begin n_errors++; $display("FAIL er_ready: got %b want 1", data_ready); end
    lit = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++; if (frame_start !== 1'b1) begin n_errors++; $display("FAIL er_restart_fs: got %b want 1", frame_start); end
      end
      if (k == BC) begin
        n_checks++; if (led_row !== 4'b0001) begin n_errors++; $display("FAIL er_restart_row0: got %b want 0001", led_row); end
      end
      if (led_col !== 4'b0000) lit++;
      n_checks++; if (led_row !== exp_row()) begin n_errors++; $display("FAIL er_row k=%0d: got %b want %b", k, led_row, exp_row()); end
    end
    n_checks++; if (lit != 0) begin n_errors++; $display("FAIL er_display_cleared: got %0d lit clocks want 0", lit); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n_checks++; if (led_row !== exp_row()) begin n_errors++; $display("FAIL rnd_row k=%0d: got %b want %b", k, led_row, exp_row()); end
      n_checks++; if (led_col !== exp_col()) begin n_errors++; $display("FAIL rnd_col k=%0d: got %b want %b", k, led_col, exp_col()); end
      n_checks++; if (frame_start !== m_fs) begin n_errors++; $display("FAIL rnd_fs k=%0d: got %b want %b", k, frame_start, m_fs); end
      n_checks++; if (data_ready !== !m_pend_full) begin n_errors++; $display("FAIL rnd_ready k=%0d: got %b want %b", k, data_ready, !m_pend_full); end
      n_checks++; if (led_row_n !== ~exp_row() || led_col_n !== ~exp_col()) begin n_errors++; $display("FAIL rnd_pins_n k=%0d: row %b col %b", k, led_row_n, led_col_n); end
      n_checks++; if ($countones(led_row) > 1) begin n_errors++; $display("FAIL rnd_onehot k=%0d: row %b", k, led_row); end
      rst_n = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 249) == 0) enable = !enable;
      if ($urandom_range(0, 59) == 0) brightness = BW'($urandom);
      if (!data_valid || m_acc) begin
        data_valid = ($urandom_range(0, 3) == 0);
        data       = 16'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_bitmap();
    test_pwm();
    test_back_to_back();
    test_polarity();
    test_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
